// File: rtl/cra_pkg.sv
// cra_pkg: shared slice width and controller state encoding for the sequential adder
package cra_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cra4bits.sv
// cra4bits: combinational 4-bit carry-ripple slice, exporting the carry into bit 3 for overflow
module cra4bits
  import cra_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c3
);
  logic [SLICE_W:0] w_c;
  // ripple the carry bit by bit through the slice
  always_comb begin
    w_c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = w_c[SLICE_W];
  assign c3   = w_c[SLICE_W-1];
endmodule

// File: rtl/cra_seq_ctrl.sv
// cra_seq_ctrl: sequential adder reusing one 4-bit ripple slice, LSB slice first; optional ovf port via CRA_SEQ_OVF_EN
module cra_seq_ctrl
  import cra_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CRA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [IW-1:0]        r_idx;
  logic                 r_carry;
  logic [SLICE_W-1:0]   w_a_sl, w_b_sl, w_s;
  logic                 w_co, w_last, w_accept;
`ifdef CRA_SEQ_OVF_EN
  logic                 w_c3;
`endif

  assign w_last    = r_idx == IW'(NSLICE - 1);
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign cout      = r_carry;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state: accept in IDLE, run NSLICE cycles, hold DONE until consumed
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // select the current operand slices
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_sl = r_a[k*SLICE_W +: SLICE_W];
        w_b_sl = r_b[k*SLICE_W +: SLICE_W];
      end
    end
  end

  cra4bits u_slice (
    .a    (w_a_sl),
    .b    (w_b_sl),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co),
`ifdef CRA_SEQ_OVF_EN
    .c3   (w_c3)
`else
    .c3   ()
`endif
  );

  // latch operands on acceptance, then write one result slice per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      sum     <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_carry <= w_co;
      r_idx   <= r_idx + IW'(1);
      for (int k = 0; k < NSLICE; k++)
        if (r_idx == IW'(k)) sum[k*SLICE_W +: SLICE_W] <= w_s;
    end
  end

`ifdef CRA_SEQ_OVF_EN
  // signed overflow from the top slice, captured on the last RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ovf <= 1'b0;
    else if (r_state == RUN && w_last) ovf <= w_c3 ^ w_co;
  end
`endif
endmodule

// File: tb/tb_cra_seq_ctrl.sv
// tb_cra_seq_ctrl: directed checks of the sequential ripple adder at WIDTH=16 and WIDTH=4
module tb_cra_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout;
  logic [15:0] sum;
  logic        v4 = 1'b0, rdy4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ir4, ov4, co4;
  logic [3:0]  s4;
`ifdef CRA_SEQ_OVF_EN
  logic        ovf, ovf4;
`endif
  int n_cmp = 0;
  int n_err = 0;

  cra_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CRA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  cra_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(rdy4),
    .sum(s4), .cout(co4)
`ifdef CRA_SEQ_OVF_EN
    , .ovf(ovf4)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic, output int lat);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (sum !== 16'h0) begin n_err++; $display("FAIL reset_sum got %h exp 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b exp 0", cout); end
`ifdef CRA_SEQ_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_carry_chain;
    int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL chain_latency got %0d exp 4", lat); end
    n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL chain_sum got %h exp 0000", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL chain_cout got %b exp 1", cout); end
`ifdef CRA_SEQ_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL chain_ovf got %b exp 0", ovf); end
`endif
    release_result;
  endtask

  task automatic test_overflow;
    int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    n_cmp++; if (sum !== 16'h8000) begin n_err++; $display("FAIL ovf_pos_sum got %h exp 8000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL ovf_pos_cout got %b exp 0", cout); end
`ifdef CRA_SEQ_OVF_EN
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pos_ovf got %b exp 1", ovf); end
`endif
    release_result;
    run_op(16'h8000, 16'h8000, 1'b0, lat);
    n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL ovf_neg_sum got %h exp 0000", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL ovf_neg_cout got %b exp 1", cout); end
`ifdef CRA_SEQ_OVF_EN
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_neg_ovf got %b exp 1", ovf); end
`endif
    release_result;
  endtask

  task automatic test_hold;
    int lat;
    run_op(16'h1234, 16'h4321, 1'b1, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL hold_latency got %0d exp 4", lat); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got %b exp 1", i, out_valid); end
      n_cmp++; if (sum !== 16'h5556) begin n_err++; $display("FAIL hold_sum[%0d] got %h exp 5556", i, sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL hold_cout[%0d] got %b exp 0", i, cout); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready); end
      tick;
    end
    release_result;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid got %b exp 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_mid_reset;
    int lat;
    logic seen;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (sum !== 16'h0) begin n_err++; $display("FAIL midrst_sum got %h exp 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL midrst_cout got %b exp 0", cout); end
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen |= out_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_valid got %b exp 0", seen); end
    n_cmp++; if (sum !== 16'h0) begin n_err++; $display("FAIL midrst_sum_after got %h exp 0000", sum); end
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL midrst_new_latency got %0d exp 4", lat); end
    n_cmp++; if (sum !== 16'h0002) begin n_err++; $display("FAIL midrst_new_sum got %h exp 0002", sum); end
    release_result;
  endtask

  task automatic test_back_to_back;
    a = 16'h0F0F; b = 16'h1010; cin = 1'b0; in_valid = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      a = 16'hA5A5 ^ 16'(i * 16'h1111);
      b = 16'h5A5A + 16'(i);
      cin = 1'b1;
      tick;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready[%0d] got %b exp 0", i, in_ready); end
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    n_cmp++; if (sum !== 16'h1F1F) begin n_err++; $display("FAIL b2b_sum got %h exp 1f1f", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL b2b_cout got %b exp 0", cout); end
    in_valid = 1'b0;
    release_result;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle got %b exp 1", in_ready); end
  endtask

  task automatic test_width4;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; v4 = 1'b1;
    tick;
    v4 = 1'b0;
    n_cmp++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL w4_early_valid got %b exp 0", ov4); end
    tick;
    n_cmp++; if (ov4 !== 1'b1) begin n_err++; $display("FAIL w4_valid got %b exp 1", ov4); end
    n_cmp++; if (s4 !== 4'hF) begin n_err++; $display("FAIL w4_sum got %h exp f", s4); end
    n_cmp++; if (co4 !== 1'b1) begin n_err++; $display("FAIL w4_cout got %b exp 1", co4); end
    rdy4 = 1'b1;
    tick;
    rdy4 = 1'b0;
    n_cmp++; if (ir4 !== 1'b1) begin n_err++; $display("FAIL w4_idle got %b exp 1", ir4); end
  endtask

  initial begin
    test_reset;
    test_carry_chain;
    test_overflow;
    test_hold;
    test_mid_reset;
    test_back_to_back;
    test_width4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cra_seq_ctrl.md
CRA_SEQ_CTRL -- requirements
Module: cra_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, operand request.
REQ-005 SHALL have port in_ready, output, 1, controller can accept operands.
REQ-006 SHALL have ports a and b, input, WIDTH each, operands.
REQ-007 SHALL have port cin, input, 1, carry-in for the whole add.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port sum, output, WIDTH, result.
REQ-011 SHALL have port cout, output, 1, final carry-out.
REQ-012 SHALL have port ovf, output, 1, signed overflow; present only when CRA_SEQ_OVF_EN is defined.

Function
REQ-013 SHALL compute {cout,sum} = a + b + cin by sequencing one 4-bit ripple slice over NSLICE = WIDTH/4 cycles, LSB slice first.
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; when in_valid=1 at a clock edge, SHALL latch a, b and cin, clear the slice index, and go to RUN.
REQ-016 RUN: in_ready=0; each cycle SHALL add slice[idx] of the latched operands with the carry register, write the 4-bit result into sum[4*idx+3:4*idx], store the slice carry-out in the carry register, and increment idx.
REQ-017 On the RUN cycle with idx = NSLICE-1, SHALL go to DONE; out_valid SHALL rise exactly NSLICE clock edges after the acceptance edge.
REQ-018 DONE: out_valid=1, in_ready=0; sum, cout and ovf SHALL be held stable until out_ready=1 is sampled, then go to IDLE.
REQ-019 out_valid=1 with out_ready=0 SHALL hold DONE indefinitely with no change to any output.
REQ-020 in_valid while not in IDLE SHALL be ignored; a, b and cin changes after acceptance SHALL NOT affect the result.
REQ-021 WIDTH=4 SHALL give NSLICE=1: one RUN cycle, then DONE.
REQ-022 cout SHALL equal the final carry register; sum SHALL be partially updated but unqualified while out_valid=0.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry register=0.
REQ-024 Reset during RUN or DONE SHALL abort the operation and discard the result; the first edge after release SHALL behave as IDLE.

Configuration
REQ-025 With CRA_SEQ_OVF_EN defined, SHALL register ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), captured on the last RUN cycle, valid with out_valid.
REQ-026 Without CRA_SEQ_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package cra_pkg SHALL hold SLICE_W=4 and the state enum (IDLE, RUN, DONE).
REQ-028 One sub-module SHALL be instantiated: cra4bits, a combinational 4-bit carry-ripple slice with cin, s[3:0], cout, and the carry into bit 3 exported for overflow.
REQ-029 The idx counter SHALL be $clog2(NSLICE) bits wide, minimum 1.

Verification (WIDTH=16 unless stated)
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 edges after acceptance, sum=0x0000, cout=1, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1 (CRA_SEQ_OVF_EN defined); no ovf port when undefined.
REQ-032 a=0x1234, b=0x4321, cin=1, out_ready held 0 for 5 cycles -> sum=0x5556, cout=0 stable throughout; IDLE one edge after out_ready=1.
REQ-033 rst_n pulsed low after 2 RUN cycles -> out_valid never rises, all outputs 0; new request 0x0001+0x0001 -> sum=0x0002.
REQ-034 in_valid held high with changing a/b during RUN -> only the first operands are summed, in_ready=0 until return to IDLE.
REQ-035 WIDTH=4: a=0xF, b=0xF, cin=1 -> out_valid 1 edge after acceptance, sum=0xF, cout=1.
